// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Shares one 16-bit ripple adder between two requesters. Each request is a
//   32-bit add or subtract that runs as two passes: the low half first, then
//   the high half, with the carry held in a register between the passes.
//   When both requesters are pending, the adder is granted by round-robin.
//
// Ports
//   Clk            system clock, rising edge
//   Reset_n        asynchronous active-low reset
//   req0/req1      request pending (level, held until matching done)
//   a0/a1, b0/b1   32-bit operands
//   sub0/sub1      1 = A-B, 0 = A+B
//   done0/done1    one-cycle pulse: the result on sum/cout belongs to that requester
//   sum, cout      registered result and carry out of bit 31; held until the next op completes
//   busy           high while an operation is in flight (LO, HI, DONE)

// 16-bit ripple-carry adder shared by both requesters.
// Ports: a, b operands; cin carry in; sum result; cout carry out of the MSB.
module ripple_adder #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < DATA_W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[DATA_W];

endmodule

module adder_arbiter #(
  parameter bit PRIORITY_INIT = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic        sub0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic        sub1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] sum,
  output logic        cout,
  output logic        busy
);

  localparam int DATA_W = 32;
  localparam int HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  logic                ptr;       // requester that wins the next tie
  logic                gnt_id;    // requester owning the running operation
  logic                carry;     // carry from the low pass into the high pass
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic                cin_q;
  logic [HALF_W-1:0]   lo_res;

  logic                grant;
  logic                grant_id;

  logic [HALF_W-1:0]   add_a;
  logic [HALF_W-1:0]   add_b;
  logic                add_cin;
  logic [HALF_W-1:0]   add_sum;
  logic                add_cout;

  // Arbitration: a single pending request wins outright; a tie goes to ptr.
  always_comb begin
    grant    = (state == IDLE) && (req0 || req1);
    grant_id = (req0 && req1) ? ptr : req1;
  end

  // Adder input mux; the adder is parked at zero outside the two passes.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      LO: begin
        add_a   = op_a[HALF_W-1:0];
        add_b   = op_b[HALF_W-1:0];
        add_cin = cin_q;
      end
      HI: begin
        add_a   = op_a[DATA_W-1:HALF_W];
        add_b   = op_b[DATA_W-1:HALF_W];
        add_cin = carry;
      end
      default: begin
      end
    endcase
  end

  ripple_adder #(
    .DATA_W (HALF_W)
  ) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Operand capture at grant. Subtract is A + ~B + 1, so B is inverted here
  // and the +1 enters as the low-pass carry in. Later changes on the request
  // inputs cannot reach the running operation.
  always_ff @(posedge Clk) begin
    if (grant) begin
      if (grant_id) begin
        op_a  <= a1;
        op_b  <= sub1 ? ~b1 : b1;
        cin_q <= sub1;
      end else begin
        op_a  <= a0;
        op_b  <= sub0 ? ~b0 : b0;
        cin_q <= sub0;
      end
    end
    if (state == LO) begin
      lo_res <= add_sum;
    end
  end

  // Sequencer: IDLE -> LO -> HI -> DONE -> IDLE, all outputs registered.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      ptr    <= PRIORITY_INIT;
      gnt_id <= 1'b0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (grant) begin
            gnt_id <= grant_id;
            busy   <= 1'b1;
            state  <= LO;
          end
        end
        LO: begin
          carry <= add_cout;
          state <= HI;
        end
        HI: begin
          sum   <= {add_sum, lo_res};
          cout  <= add_cout;
          // done is set here so it is high exactly during DONE.
          done0 <= ~gnt_id;
          done1 <= gnt_id;
          state <= DONE;
        end
        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          ptr   <= ~gnt_id;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: scoreboard of expected results pushed when a
// request is driven, popped and compared whenever a done pulse appears.
module tb_adder_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        req0 = 1'b0;
  logic [31:0] a0 = '0;
  logic [31:0] b0 = '0;
  logic        sub0 = 1'b0;
  logic        req1 = 1'b0;
  logic [31:0] a1 = '0;
  logic [31:0] b1 = '0;
  logic        sub1 = 1'b0;
  logic        done0;
  logic        done1;
  logic [31:0] sum;
  logic        cout;
  logic        busy;

  adder_arbiter #(
    .PRIORITY_INIT (1'b0)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .req0    (req0),
    .a0      (a0),
    .b0      (b0),
    .sub0    (sub0),
    .req1    (req1),
    .a1      (a1),
    .b1      (b1),
    .sub1    (sub1),
    .done0   (done0),
    .done1   (done1),
    .sum     (sum),
    .cout    (cout),
    .busy    (busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        id;
    logic [31:0] sum;
    logic        cout;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [31:0] a,
                                 input logic [31:0] b, input logic sub);
    logic [32:0] r;
    exp_t e;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + 33'd1;
    else     r = {1'b0, a} + {1'b0, b};
    e.id   = id;
    e.sum  = r[31:0];
    e.cout = r[32];
    return e;
  endfunction

  // Operand patterns for the tie tests.
  function automatic logic [31:0] fa(input logic id, input int k);
    return id ? ((32'(k) + 32'd3) << 16) : (32'h8000_0000 + 32'(k));
  endfunction
  function automatic logic [31:0] fb(input logic id, input int k);
    return id ? (32'd3 + 32'(k)) : (32'h8000_0001 << k);
  endfunction

  // Scoreboard monitor.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset_n) begin
      if (done0 && done1) begin
        chk("both_done", 1, 0);
      end else if (done0 || done1) begin
        chk("busy_in_done", busy, 1);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_id", done1, e.id);
          chk("sum", sum, e.sum);
          chk("cout", cout, e.cout);
        end
      end
    end
  end

  task automatic wait_done(input logic id, output int n);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      if (id ? done1 : done0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic sub);
    int n;
    @(posedge Clk); #1;
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; sub1 = sub; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; sub0 = sub; end
    sb.push_back(model(id, a, b, sub));
    wait_done(id, n);
    req0 = 1'b0;
    req1 = 1'b0;
    if (n == 0) chk("op_timeout", 0, 1);
    else        chk("op_latency", n, 4);
  endtask

  // Both requesters held high; expected grant order strictly alternates
  // starting from requester 0.
  task automatic run_tie(input int nops);
    int k0 = 0;
    int k1 = 0;
    int nd = 0;
    int last = 0;
    for (int i = 0; i < nops; i++) begin
      logic id;
      id = i[0];
      sb.push_back(model(id, fa(id, i / 2), fb(id, i / 2), id));
    end
    @(posedge Clk); #1;
    a0 = fa(1'b0, 0); b0 = fb(1'b0, 0); sub0 = 1'b0;
    a1 = fa(1'b1, 0); b1 = fb(1'b1, 0); sub1 = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int c = 0; c < 60 && nd < nops; c++) begin
      @(negedge Clk);
      if (done0 || done1) begin
        if (nd > 0) chk("tie_spacing", cyc - last, 4);
        last = cyc;
        nd++;
        if (done0) begin k0++; a0 = fa(1'b0, k0); b0 = fb(1'b0, k0); end
        else       begin k1++; a1 = fa(1'b1, k1); b1 = fb(1'b1, k1); end
        if (nd == nops) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    if (nd < nops) begin
      chk("tie_timeout", nd, nops);
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state.
    repeat (2) @(negedge Clk);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", {done1, done0}, 0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", {done1, done0}, 0);

    // Carry across halves, full wrap, and subtracts both ways.
    run_op(1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(1'b0, 32'd5, 32'd7, 1'b1);
    run_op(1'b0, 32'd7, 32'd5, 1'b1);
    run_op(1'b1, 32'h1234_5678, 32'h8765_4321, 1'b1);

    // Tie: order 0,1,0,1 with 4-cycle spacing.
    run_tie(4);

    // Operands and req changed right after the grant edge.
    @(posedge Clk); #1;
    req0 = 1'b1; a0 = 32'h1234_5678; b0 = 32'h1111_1111; sub0 = 1'b0;
    sb.push_back(model(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0));
    @(posedge Clk); #1;
    a0 = 32'hDEAD_BEEF; b0 = 32'h0; sub0 = 1'b1; req0 = 1'b0;
    wait_done(1'b0, n);
    if (n == 0) chk("late_change_timeout", 0, 1);
    else        chk("late_change_latency", n, 3);

    // Reset during HI: everything clears at once, no done pulse follows.
    @(posedge Clk); #1;
    req0 = 1'b1; a0 = 32'h0F0F_0F0F; b0 = 32'h0101_0101; sub0 = 1'b0;
    repeat (3) @(negedge Clk);
    chk("pre_rst_busy", busy, 1);
    Reset_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_done", {done1, done0}, 0);
    @(negedge Clk);
    chk("midrst_done2", {done1, done0}, 0);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", {done1, done0}, 0);

    // After reset the pointer favours requester 0 again.
    run_tie(2);

    repeat (6) @(negedge Clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
